// File: rtl/id_hazard_unit_if.sv
// Bundle between the decoder/pipeline side and the ID operand-hazard unit.
// The hazard unit connects through the slave modport; the driving side uses master.
interface id_hazard_unit_if #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 3,
   parameter int IDX_W      = 5
);
   logic                          id_valid_i;
   logic [NUM_SRC*IDX_W-1:0]      id_rs_index_i;
   logic [NUM_SRC-1:0]            id_rs_used_i;
   logic [IDX_W-1:0]              id_rd_index_i;
   logic                          id_rd_wen_i;
   logic [NUM_STAGES-1:0]         stage_valid_i;
   logic [NUM_STAGES*IDX_W-1:0]   stage_rd_index_i;
   logic [NUM_STAGES-1:0]         stage_rd_wen_i;
   logic [NUM_STAGES-1:0]         stage_data_ready_i;
   logic                          lu_issue_i;
   logic [IDX_W-1:0]              lu_issue_rd_i;
   logic                          lu_wb_i;
   logic [IDX_W-1:0]              lu_wb_rd_i;
   logic [NUM_SRC*(NUM_STAGES+1)-1:0] fwd_sel_o;
   logic                          stall_o;
   logic [(2**IDX_W)-1:0]         pending_o;
   logic [31:0]                   stall_cnt_o;

   modport master (
      output id_valid_i, id_rs_index_i, id_rs_used_i, id_rd_index_i, id_rd_wen_i,
             stage_valid_i, stage_rd_index_i, stage_rd_wen_i, stage_data_ready_i,
             lu_issue_i, lu_issue_rd_i, lu_wb_i, lu_wb_rd_i,
      input  fwd_sel_o, stall_o, pending_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_index_i, id_rs_used_i, id_rd_index_i, id_rd_wen_i,
             stage_valid_i, stage_rd_index_i, stage_rd_wen_i, stage_data_ready_i,
             lu_issue_i, lu_issue_rd_i, lu_wb_i, lu_wb_rd_i,
      output fwd_sel_o, stall_o, pending_o, stall_cnt_o
   );
endinterface

// File: rtl/id_hazard_unit.sv
// ID-stage operand hazard unit: one-hot bypass select, load-use / scoreboard / WAW stall.
// Optional stall-cycle counter built only when ID_HAZARD_PERF_EN is defined.
module id_hazard_unit #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 3,
   parameter int IDX_W      = 5
) (
   input  logic         clk,
   input  logic         rst,
   id_hazard_unit_if.slave hz
);
   localparam int NUM_REGS = 2**IDX_W;
   localparam int SEL_W    = NUM_STAGES + 1;

   logic [NUM_REGS-1:0]      pending_q, pending_d;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic [NUM_SRC-1:0]       lu_stall;
   logic [NUM_SRC-1:0]       raw_stall;
   logic                     waw_stall;

   always_comb begin
      logic [IDX_W-1:0] rs;
      logic [IDX_W-1:0] rd;
      logic             active;
      logic             hit;
      logic             win_rdy;
      fwd_sel   = '0;
      lu_stall  = '0;
      raw_stall = '0;
      rs        = '0;
      rd        = '0;
      active    = 1'b0;
      hit       = 1'b0;
      win_rdy   = 1'b1;
      for (int s = 0; s < NUM_SRC; s++) begin
         rs      = hz.id_rs_index_i[s*IDX_W +: IDX_W];
         active  = hz.id_rs_used_i[s] && (rs != '0);
         hit     = 1'b0;
         win_rdy = 1'b1;
         // Youngest matching writer wins; an unready winner stalls rather than falling through.
         for (int k = 0; k < NUM_STAGES; k++) begin
            rd = hz.stage_rd_index_i[k*IDX_W +: IDX_W];
            if (!hit && active && hz.stage_valid_i[k] && hz.stage_rd_wen_i[k] &&
                (rd != '0) && (rd == rs)) begin
               hit                    = 1'b1;
               win_rdy                = hz.stage_data_ready_i[k];
               fwd_sel[s*SEL_W + k + 1] = 1'b1;
            end
         end
         if (!hit) fwd_sel[s*SEL_W] = 1'b1;
         lu_stall[s]  = hit && !win_rdy;
         raw_stall[s] = active && !hit && pending_q[rs];
      end
   end

   assign waw_stall = hz.id_rd_wen_i && (hz.id_rd_index_i != '0) && pending_q[hz.id_rd_index_i];

   assign hz.fwd_sel_o = fwd_sel;
   assign hz.stall_o   = hz.id_valid_i && ((|lu_stall) || (|raw_stall) || waw_stall);
   assign hz.pending_o = pending_q;

   // Scoreboard next state: clear on writeback first so a same-cycle issue wins.
   always_comb begin
      pending_d = pending_q;
      if (hz.lu_wb_i) pending_d[hz.lu_wb_rd_i] = 1'b0;
      if (hz.lu_issue_i && (hz.lu_issue_rd_i != '0)) pending_d[hz.lu_issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

`ifdef ID_HAZARD_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hz.stall_o) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign hz.stall_cnt_o = stall_cnt_q;
`else
   assign hz.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed self-checking bench for id_hazard_unit (default 2 sources, 3 stages, 5-bit index).
module tb_id_hazard_unit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   id_hazard_unit_if #(.NUM_SRC(2), .NUM_STAGES(3), .IDX_W(5)) hz ();

   id_hazard_unit #(.NUM_SRC(2), .NUM_STAGES(3), .IDX_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      hz.id_valid_i         = 1'b0;
      hz.id_rs_index_i      = '0;
      hz.id_rs_used_i       = '0;
      hz.id_rd_index_i      = '0;
      hz.id_rd_wen_i        = 1'b0;
      hz.stage_valid_i      = '0;
      hz.stage_rd_index_i   = '0;
      hz.stage_rd_wen_i     = '0;
      hz.stage_data_ready_i = '0;
      hz.lu_issue_i         = 1'b0;
      hz.lu_issue_rd_i      = '0;
      hz.lu_wb_i            = 1'b0;
      hz.lu_wb_rd_i         = '0;
   endtask

   task automatic set_stage(input int k, input logic [4:0] rd, input logic rdy);
      hz.stage_valid_i[k]            = 1'b1;
      hz.stage_rd_wen_i[k]           = 1'b1;
      hz.stage_rd_index_i[k*5 +: 5]  = rd;
      hz.stage_data_ready_i[k]       = rdy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (hz.pending_o !== 32'h0) begin
         bad++; $display("FAIL reset_pending got=%h exp=%h", hz.pending_o, 32'h0);
      end
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL reset_stall got=%b exp=0", hz.stall_o);
      end
      total++;
      if (hz.fwd_sel_o !== 8'b0001_0001) begin
         bad++; $display("FAIL reset_fwd got=%b exp=%b", hz.fwd_sel_o, 8'b0001_0001);
      end
      total++;
      if (hz.stall_cnt_o !== 32'h0) begin
         bad++; $display("FAIL reset_cnt got=%h exp=0", hz.stall_cnt_o);
      end
   endtask

   task automatic test_fwd_priority();
      next_cycle();
      clear_inputs();
      hz.id_valid_i          = 1'b1;
      hz.id_rs_index_i[4:0]  = 5'd5;
      hz.id_rs_used_i        = 2'b01;
      set_stage(0, 5'd5, 1'b1);
      set_stage(1, 5'd5, 1'b1);
      @(negedge clk);
      total++;
      if (hz.fwd_sel_o[3:0] !== 4'b0010) begin
         bad++; $display("FAIL prio_stage0 got=%b exp=%b", hz.fwd_sel_o[3:0], 4'b0010);
      end
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL prio_stall got=%b exp=0", hz.stall_o);
      end
      next_cycle();
      hz.stage_valid_i[0] = 1'b0;
      @(negedge clk);
      total++;
      if (hz.fwd_sel_o[3:0] !== 4'b0100) begin
         bad++; $display("FAIL prio_stage1 got=%b exp=%b", hz.fwd_sel_o[3:0], 4'b0100);
      end
      set_stage(2, 5'd5, 1'b1);
      hz.stage_valid_i[1] = 1'b0;
      #1;
      total++;
      if (hz.fwd_sel_o[3:0] !== 4'b1000) begin
         bad++; $display("FAIL prio_stage2 got=%b exp=%b", hz.fwd_sel_o[3:0], 4'b1000);
      end
   endtask

   task automatic test_load_use();
      next_cycle();
      clear_inputs();
      hz.id_valid_i          = 1'b1;
      hz.id_rs_index_i[9:5]  = 5'd7;
      hz.id_rs_used_i        = 2'b10;
      set_stage(0, 5'd7, 1'b0);
      set_stage(1, 5'd7, 1'b1);
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b1) begin
         bad++; $display("FAIL lu_stall got=%b exp=1", hz.stall_o);
      end
      total++;
      if (hz.fwd_sel_o[7:4] !== 4'b0010) begin
         bad++; $display("FAIL lu_fwd got=%b exp=%b", hz.fwd_sel_o[7:4], 4'b0010);
      end
      next_cycle();
      hz.stage_data_ready_i[0] = 1'b1;
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL lu_release got=%b exp=0", hz.stall_o);
      end
   endtask

   task automatic test_x0_unused();
      next_cycle();
      clear_inputs();
      hz.id_valid_i          = 1'b1;
      hz.id_rs_index_i       = {5'd3, 5'd0};
      hz.id_rs_used_i        = 2'b01;
      set_stage(0, 5'd0, 1'b0);
      set_stage(1, 5'd3, 1'b0);
      set_stage(2, 5'd3, 1'b1);
      @(negedge clk);
      total++;
      if (hz.fwd_sel_o !== 8'b0001_0001) begin
         bad++; $display("FAIL x0_unused_fwd got=%b exp=%b", hz.fwd_sel_o, 8'b0001_0001);
      end
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL x0_unused_stall got=%b exp=0", hz.stall_o);
      end
   endtask

   task automatic test_scoreboard();
      next_cycle();
      clear_inputs();
      hz.id_valid_i         = 1'b1;
      hz.id_rs_index_i[4:0] = 5'd9;
      hz.id_rs_used_i       = 2'b01;
      hz.lu_issue_i         = 1'b1;
      hz.lu_issue_rd_i      = 5'd9;
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL sb_issue_cycle got=%b exp=0", hz.stall_o);
      end
      next_cycle();
      hz.lu_issue_i = 1'b0;
      @(negedge clk);
      total++;
      if (hz.pending_o[9] !== 1'b1 || hz.stall_o !== 1'b1) begin
         bad++; $display("FAIL sb_pending pend=%b stall=%b exp=1/1", hz.pending_o[9], hz.stall_o);
      end
      next_cycle();
      next_cycle();
      next_cycle();
      hz.lu_wb_i    = 1'b1;
      hz.lu_wb_rd_i = 5'd9;
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b1) begin
         bad++; $display("FAIL sb_wb_cycle got=%b exp=1", hz.stall_o);
      end
      next_cycle();
      hz.lu_wb_i = 1'b0;
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b0 || hz.pending_o[9] !== 1'b0) begin
         bad++; $display("FAIL sb_release stall=%b pend=%b exp=0/0", hz.stall_o, hz.pending_o[9]);
      end
      // issue, then issue and writeback together: set must win
      next_cycle();
      hz.lu_issue_i    = 1'b1;
      hz.lu_issue_rd_i = 5'd9;
      next_cycle();
      hz.lu_wb_i    = 1'b1;
      hz.lu_wb_rd_i = 5'd9;
      next_cycle();
      hz.lu_issue_i = 1'b0;
      hz.lu_wb_i    = 1'b0;
      @(negedge clk);
      total++;
      if (hz.pending_o !== 32'h0000_0200) begin
         bad++; $display("FAIL sb_set_wins got=%h exp=%h", hz.pending_o, 32'h0000_0200);
      end
      set_stage(0, 5'd9, 1'b1);
      #1;
      total++;
      if (hz.stall_o !== 1'b0 || hz.fwd_sel_o[3:0] !== 4'b0010) begin
         bad++; $display("FAIL sb_stage_override stall=%b fwd=%b exp=0/0010", hz.stall_o, hz.fwd_sel_o[3:0]);
      end
      hz.stage_valid_i = '0;
      hz.id_rs_used_i  = 2'b00;
      hz.id_rd_index_i = 5'd9;
      hz.id_rd_wen_i   = 1'b1;
      #1;
      total++;
      if (hz.stall_o !== 1'b1) begin
         bad++; $display("FAIL sb_waw got=%b exp=1", hz.stall_o);
      end
      hz.id_valid_i = 1'b0;
      #1;
      total++;
      if (hz.stall_o !== 1'b0) begin
         bad++; $display("FAIL sb_waw_invalid got=%b exp=0", hz.stall_o);
      end
      hz.id_valid_i = 1'b1;
      hz.lu_wb_i    = 1'b1;
      hz.lu_wb_rd_i = 5'd9;
      next_cycle();
      hz.lu_wb_i = 1'b0;
      @(negedge clk);
      total++;
      if (hz.stall_o !== 1'b0 || hz.pending_o !== 32'h0) begin
         bad++; $display("FAIL sb_waw_clear stall=%b pend=%h exp=0/0", hz.stall_o, hz.pending_o);
      end
   endtask

   task automatic test_reset_perf();
      next_cycle();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      hz.id_valid_i         = 1'b1;
      hz.id_rs_index_i[4:0] = 5'd4;
      hz.id_rs_used_i       = 2'b01;
      set_stage(0, 5'd4, 1'b0);
      for (int i = 0; i < 10; i++) next_cycle();
      hz.id_valid_i = 1'b0;
      @(negedge clk);
      total++;
`ifdef ID_HAZARD_PERF_EN
      if (hz.stall_cnt_o !== 32'd10) begin
         bad++; $display("FAIL perf_count got=%0d exp=10", hz.stall_cnt_o);
      end
`else
      if (hz.stall_cnt_o !== 32'd0) begin
         bad++; $display("FAIL perf_tied got=%0d exp=0", hz.stall_cnt_o);
      end
`endif
      next_cycle();
      hz.lu_issue_i    = 1'b1;
      hz.lu_issue_rd_i = 5'd12;
      next_cycle();
      hz.lu_issue_i = 1'b0;
      hz.id_valid_i = 1'b1;
      @(negedge clk);
      total++;
      if (hz.pending_o !== 32'h0000_1000) begin
         bad++; $display("FAIL perf_pending_set got=%h exp=%h", hz.pending_o, 32'h0000_1000);
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      hz.id_valid_i = 1'b0;
      @(negedge clk);
      total++;
      if (hz.pending_o !== 32'h0 || hz.stall_cnt_o !== 32'h0) begin
         bad++; $display("FAIL mid_reset pend=%h cnt=%h exp=0/0", hz.pending_o, hz.stall_cnt_o);
      end
`ifdef ID_HAZARD_PERF_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      hz.id_valid_i = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      total++;
      if (hz.stall_cnt_o !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL perf_saturate got=%h exp=FFFFFFFF", hz.stall_cnt_o);
      end
      hz.id_valid_i = 1'b0;
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      clear_inputs();
      test_reset();
      test_fwd_priority();
      test_load_use();
      test_x0_unused();
      test_scoreboard();
      test_reset_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
